// File: rtl/palette_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | palette_port_arbiter_if                                                    |
// | Pixel, host, cycling-control and palette RAM signals of the arbiter.       |
// | Optional: PALETTE_READBACK_EN adds the host readback signals.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface palette_port_arbiter_if #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 24,
  parameter int PERIOD_W = 8
);
  logic                pix_valid;
  logic [ADDR_W-1:0]   pix_iter;
  logic                pix_rgb_valid;
  logic [DATA_W-1:0]   pix_rgb;
  logic                host_wr_valid;
  logic                host_wr_ready;
  logic [ADDR_W-1:0]   host_wr_addr;
  logic [DATA_W-1:0]   host_wr_data;
  logic                frame_start;
  logic                cycle_en;
  logic [PERIOD_W-1:0] cycle_period;
  logic [ADDR_W-1:0]   cycle_offset;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
`ifdef PALETTE_READBACK_EN
  logic                host_rd_valid;
  logic [ADDR_W-1:0]   host_rd_addr;
  logic                host_rd_ready;
  logic                host_rd_data_valid;
  logic [DATA_W-1:0]   host_rd_data;
`endif

  // Arbiter side.
  modport slave (
    input  pix_valid, pix_iter, host_wr_valid, host_wr_addr, host_wr_data,
           frame_start, cycle_en, cycle_period, mem_rdata,
`ifdef PALETTE_READBACK_EN
    input  host_rd_valid, host_rd_addr,
    output host_rd_ready, host_rd_data_valid, host_rd_data,
`endif
    output pix_rgb_valid, pix_rgb, host_wr_ready, cycle_offset,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Environment side: pipeline, host and RAM.
  modport master (
    output pix_valid, pix_iter, host_wr_valid, host_wr_addr, host_wr_data,
           frame_start, cycle_en, cycle_period, mem_rdata,
`ifdef PALETTE_READBACK_EN
    output host_rd_valid, host_rd_addr,
    input  host_rd_ready, host_rd_data_valid, host_rd_data,
`endif
    input  pix_rgb_valid, pix_rgb, host_wr_ready, cycle_offset,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/palette_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | palette_port_arbiter                                                       |
// | Shares the single-port palette RAM between pixel lookups (priority) and    |
// | host writes, and applies a per-frame rotating palette offset.              |
// | Optional: PALETTE_READBACK_EN adds a lowest-priority host read port.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module palette_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 24,
  parameter int PERIOD_W = 8
) (
  input wire clk,
  input wire rst_n,
  palette_port_arbiter_if.slave bus
);
  localparam int                c_LAST_INT = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W:0]   c_MOD      = c_LAST_INT[ADDR_W:0];
  localparam logic [ADDR_W-1:0] c_OFF_MAX  = ADDR_W'(c_LAST_INT - 1);
  localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);
  localparam logic [PERIOD_W-1:0] c_CNT_ONE = PERIOD_W'(1);

  typedef enum logic [1:0] {
    CYC_OFF  = 2'd0,
    CYC_WAIT = 2'd1,
    CYC_STEP = 2'd2
  } cyc_state_t;

  cyc_state_t          r_state, w_state_nxt;
  logic [PERIOD_W-1:0] r_cnt, w_cnt_nxt, w_cnt_last;
  logic [ADDR_W-1:0]   r_offset, w_offset_nxt;

  logic                w_pix_go, w_wr_go, w_rd_go;
  logic [ADDR_W-1:0]   w_iter_m1, w_pix_addr;
  logic [ADDR_W:0]     w_sum, w_mod;
  logic [DATA_W-1:0]   w_rdata;
  logic                r_pix_v0, r_pix_v1;

  // Arbitration: pixel, then write, then (optional) read.
  assign w_pix_go           = bus.pix_valid;
  assign w_wr_go            = bus.host_wr_valid && !bus.pix_valid;
  assign bus.host_wr_ready  = !bus.pix_valid && rst_n;
  assign w_rdata            = bus.mem_rdata;
  assign bus.cycle_offset   = r_offset;

`ifdef PALETTE_READBACK_EN
  logic r_rd_v0, r_rd_v1;
  assign w_rd_go           = bus.host_rd_valid && !bus.pix_valid && !bus.host_wr_valid;
  assign bus.host_rd_ready = !bus.pix_valid && !bus.host_wr_valid && rst_n;
`else
  assign w_rd_go = 1'b0;
`endif

  // Entry 0 is pinned; entries 1..255 rotate modulo 255.
  assign w_iter_m1  = bus.pix_iter - c_ONE;
  assign w_sum      = {1'b0, w_iter_m1} + {1'b0, r_offset};
  assign w_mod      = (w_sum >= c_MOD) ? (w_sum - c_MOD) : w_sum;
  assign w_pix_addr = (bus.pix_iter == '0) ? '0 : (w_mod[ADDR_W-1:0] + c_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_en        <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
      r_pix_v0          <= 1'b0;
      r_pix_v1          <= 1'b0;
      bus.pix_rgb_valid <= 1'b0;
      bus.pix_rgb       <= '0;
    end else begin
      bus.mem_en <= w_pix_go || w_wr_go || w_rd_go;
      bus.mem_we <= w_wr_go;
      if (w_pix_go) begin
        bus.mem_addr <= w_pix_addr;
      end else if (w_wr_go) begin
        bus.mem_addr <= bus.host_wr_addr;
`ifdef PALETTE_READBACK_EN
      end else if (w_rd_go) begin
        bus.mem_addr <= bus.host_rd_addr;
`endif
      end
      if (w_wr_go) begin
        bus.mem_wdata <= bus.host_wr_data;
      end
      r_pix_v0          <= w_pix_go;
      r_pix_v1          <= r_pix_v0;
      bus.pix_rgb_valid <= r_pix_v1;
      if (r_pix_v1) begin
        bus.pix_rgb <= w_rdata;
      end
    end
  end

`ifdef PALETTE_READBACK_EN
  // Readback shares the pixel pipeline; its own valid bit tags the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v0                <= 1'b0;
      r_rd_v1                <= 1'b0;
      bus.host_rd_data_valid <= 1'b0;
      bus.host_rd_data       <= '0;
    end else begin
      r_rd_v0                <= w_rd_go;
      r_rd_v1                <= r_rd_v0;
      bus.host_rd_data_valid <= r_rd_v1;
      if (r_rd_v1) begin
        bus.host_rd_data <= w_rdata;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= CYC_OFF;
      r_cnt    <= '0;
      r_offset <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_offset <= w_offset_nxt;
    end
  end

  // A period of 0 counts as 1; >= keeps a shortened period from overrunning.
  assign w_cnt_last = (bus.cycle_period == '0) ? '0 : (bus.cycle_period - c_CNT_ONE);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_offset_nxt = r_offset;
    case (r_state)
      CYC_OFF: begin
        if (bus.cycle_en) begin
          w_state_nxt = CYC_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      CYC_WAIT: begin
        if (!bus.cycle_en) begin
          w_state_nxt = CYC_OFF;
        end else if (bus.frame_start) begin
          if (r_cnt >= w_cnt_last) begin
            w_state_nxt = CYC_STEP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end
      end
      CYC_STEP: begin
        w_offset_nxt = (r_offset == c_OFF_MAX) ? '0 : (r_offset + c_ONE);
        w_state_nxt  = bus.cycle_en ? CYC_WAIT : CYC_OFF;
      end
      default: begin
        w_state_nxt = CYC_OFF;
      end
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_palette_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_palette_port_arbiter                                                    |
// | Directed bench with a synchronous 256x24 RAM model behind the arbiter.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_palette_port_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  palette_port_arbiter_if #(.ADDR_W(8), .DATA_W(24), .PERIOD_W(8)) bus ();

  palette_port_arbiter #(.ADDR_W(8), .DATA_W(24), .PERIOD_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] ram [256];

  function automatic logic [23:0] pal(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, b ^ 8'h5A};
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one pixel, check the RAM address and the colour 3 cycles later.
  task automatic pix_read(input string tag, input logic [7:0] iter,
                          input logic [7:0] exp_addr, input logic [23:0] exp_rgb);
    bus.pix_valid = 1'b1;
    bus.pix_iter  = iter;
    tick();
    check({tag, "_addr"}, {24'd0, bus.mem_addr}, {24'd0, exp_addr});
    bus.pix_valid = 1'b0;
    tick();
    tick();
    check({tag, "_vld"}, {31'd0, bus.pix_rgb_valid}, 32'd1);
    check({tag, "_rgb"}, {8'd0, bus.pix_rgb}, {8'd0, exp_rgb});
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    tick();
  endtask

  int exp_off [6] = '{0, 1, 1, 2, 2, 3};

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) ram[i] = pal(i);
    rst_n            = 1'b0;
    bus.pix_valid    = 1'b0;
    bus.pix_iter     = '0;
    bus.host_wr_valid = 1'b0;
    bus.host_wr_addr = '0;
    bus.host_wr_data = '0;
    bus.frame_start  = 1'b0;
    bus.cycle_en     = 1'b0;
    bus.cycle_period = 8'd0;
    bus.mem_rdata    = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("rst_vld", {31'd0, bus.pix_rgb_valid}, 32'd0);
    check("rst_rgb", {8'd0, bus.pix_rgb}, 32'd0);
    check("rst_off", {24'd0, bus.cycle_offset}, 32'd0);
    check("rst_ready", {31'd0, bus.host_wr_ready}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back lookups, offset 0.
    bus.pix_valid = 1'b1;
    bus.pix_iter  = 8'd0;
    tick();
    check("t1_addr0", {24'd0, bus.mem_addr}, 32'd0);
    check("t1_en", {30'd0, bus.mem_en, bus.mem_we}, 32'd2);
    bus.pix_iter = 8'd5;
    tick();
    check("t1_addr5", {24'd0, bus.mem_addr}, 32'd5);
    bus.pix_iter = 8'd255;
    tick();
    check("t1_addr255", {24'd0, bus.mem_addr}, 32'd255);
    check("t1_vld0", {31'd0, bus.pix_rgb_valid}, 32'd1);
    check("t1_rgb0", {8'd0, bus.pix_rgb}, {8'd0, pal(0)});
    bus.pix_valid = 1'b0;
    tick();
    check("t1_rgb5", {8'd0, bus.pix_rgb}, {8'd0, pal(5)});
    tick();
    check("t1_rgb255", {8'd0, bus.pix_rgb}, {8'd0, pal(255)});
    tick();
    check("t1_idle_vld", {31'd0, bus.pix_rgb_valid}, 32'd0);
    check("t1_idle_en", {31'd0, bus.mem_en}, 32'd0);

    // Host write on an idle port.
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr  = 8'h10;
    bus.host_wr_data  = 24'hABCDEF;
    #1 check("t2_ready", {31'd0, bus.host_wr_ready}, 32'd1);
    tick();
    check("t2_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd3);
    check("t2_addr", {24'd0, bus.mem_addr}, 32'h10);
    check("t2_wdata", {8'd0, bus.mem_wdata}, 32'hABCDEF);
    bus.host_wr_valid = 1'b0;
    pix_read("t2_rd", 8'd16, 8'h10, 24'hABCDEF);

    // Host stalled behind continuous pixels.
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr  = 8'h20;
    bus.host_wr_data  = 24'h123456;
    bus.pix_valid     = 1'b1;
    bus.pix_iter      = 8'd1;
    for (int i = 0; i < 10; i++) begin
      #1 check("t3_ready", {31'd0, bus.host_wr_ready}, 32'd0);
      tick();
      check("t3_no_we", {31'd0, bus.mem_we}, 32'd0);
    end
    bus.pix_valid = 1'b0;
    #1 check("t3_ready1", {31'd0, bus.host_wr_ready}, 32'd1);
    tick();
    check("t3_we", {31'd0, bus.mem_we}, 32'd1);
    check("t3_addr", {24'd0, bus.mem_addr}, 32'h20);
    bus.host_wr_valid = 1'b0;
    pix_read("t3_rd", 8'h20, 8'h20, 24'h123456);

    // Cycling, period 2.
    bus.cycle_period = 8'd2;
    bus.cycle_en     = 1'b1;
    tick();
    check("t4_off_init", {24'd0, bus.cycle_offset}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      frame_pulse();
      tick();
      check("t4_off", {24'd0, bus.cycle_offset}, exp_off[i]);
    end
    pix_read("t4_i254", 8'd254, 8'd2, pal(2));
    pix_read("t4_i255", 8'd255, 8'd3, pal(3));
    pix_read("t4_i0", 8'd0, 8'd0, pal(0));
    pix_read("t4_i1", 8'd1, 8'd4, pal(4));

    // frame_start coinciding with a pixel: the pixel sees the old offset.
    bus.cycle_period = 8'd1;
    bus.frame_start  = 1'b1;
    bus.pix_valid    = 1'b1;
    bus.pix_iter     = 8'd1;
    tick();
    check("t4_same_addr", {24'd0, bus.mem_addr}, 32'd4);
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    tick();
    check("t4_same_off", {24'd0, bus.cycle_offset}, 32'd4);
    pix_read("t4_new", 8'd1, 8'd5, pal(5));

    // Walk offset to 254 and wrap.
    for (int i = 0; i < 250; i++) frame_pulse();
    check("t5_off254", {24'd0, bus.cycle_offset}, 32'd254);
    pix_read("t5_i2", 8'd2, 8'd1, pal(1));
    pix_read("t5_i1", 8'd1, 8'd255, pal(255));
    frame_pulse();
    check("t5_wrap", {24'd0, bus.cycle_offset}, 32'd0);
    bus.cycle_period = 8'd0;
    frame_pulse();
    check("t5_p0_a", {24'd0, bus.cycle_offset}, 32'd1);
    frame_pulse();
    check("t5_p0_b", {24'd0, bus.cycle_offset}, 32'd2);
    bus.cycle_en = 1'b0;
    tick();
    frame_pulse();
    frame_pulse();
    check("t5_off_hold", {24'd0, bus.cycle_offset}, 32'd2);

    // Reset with pixels in flight.
    bus.pix_valid = 1'b1;
    bus.pix_iter  = 8'd1;
    tick();
    bus.pix_iter  = 8'd2;
    tick();
    bus.pix_iter  = 8'd3;
    tick();
    bus.pix_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_vld", {31'd0, bus.pix_rgb_valid}, 32'd0);
    check("t6_rgb", {8'd0, bus.pix_rgb}, 32'd0);
    check("t6_mem", {22'd0, bus.mem_en, bus.mem_we, bus.mem_addr}, 32'd0);
    check("t6_off", {24'd0, bus.cycle_offset}, 32'd0);
    check("t6_ready", {31'd0, bus.host_wr_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_vld", {31'd0, bus.pix_rgb_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
